// File: rtl/star_sched_pkg.sv
// -----------------------------------------------------------------------------
// star_sched_pkg
// Shared types and constants for the starfield frame scheduler.
//   sched_state_t : per-frame sequencer state encoding
//   DIV_SEL_X/Y   : operand select values seen by the divider-operand mux
// -----------------------------------------------------------------------------
package star_sched_pkg;

  typedef enum logic [2:0] {
    StInit      = 3'd0,
    StUpdate    = 3'd1,
    StReqX      = 3'd2,
    StReqY      = 3'd3,
    StWrite     = 3'd4,
    StWaitFrame = 3'd5
  } sched_state_t;

  localparam logic DIV_SEL_X = 1'b0;
  localparam logic DIV_SEL_Y = 1'b1;

endpackage

// File: rtl/star_frame_scheduler_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones; cleared only by the synchronous reset.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears the count
//   i_inc  : increment request for this cycle
//   o_cnt  : current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/star_frame_scheduler.sv
// -----------------------------------------------------------------------------
// star_frame_scheduler
// Per-frame sequencer for the starfield projection datapath. Seeds every star
// once after reset, then each pass walks all stars: Z-advance, X and Y
// projection through one shared multi-cycle divider, and a back-buffer write.
// The front/back draw buffers swap when a frame pulse is accepted.
//
// Ports
//   i_clk        : clock
//   i_rst        : synchronous active-high reset
//   i_frame      : 1-cycle pulse, start of vertical blank
//   o_init_en    : seed star[o_star_idx] from the LFSRs
//   o_upd_en     : advance Z of star[o_star_idx]
//   o_div_req    : divider request, held until i_div_ack
//   o_div_sel_y  : divider operand select (DIV_SEL_X / DIV_SEL_Y)
//   i_div_ack    : 1-cycle pulse, divider result valid
//   o_buf_we     : write projected X/Y of star[o_star_idx] to back buffer
//   o_star_idx   : star currently addressed
//   o_rd_buf     : front buffer select; back buffer is ~o_rd_buf
//   o_busy       : high from INIT through the last WRITE of a pass
//   o_overrun    : 1-cycle pulse, frame arrived while busy
//   o_ovr_cnt    : saturating overrun count (only with STAR_SCHED_OVR_CNT_EN)
//
// Build option: define STAR_SCHED_OVR_CNT_EN to add o_ovr_cnt.
// -----------------------------------------------------------------------------
module star_frame_scheduler
  import star_sched_pkg::*;
#(
  parameter int unsigned STARS_COUNT = 4,
  localparam int unsigned IDXW = $clog2(STARS_COUNT)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_frame,
  output logic            o_init_en,
  output logic            o_upd_en,
  output logic            o_div_req,
  output logic            o_div_sel_y,
  input  logic            i_div_ack,
  output logic            o_buf_we,
  output logic [IDXW-1:0] o_star_idx,
  output logic            o_rd_buf,
  output logic            o_busy,
  output logic            o_overrun
`ifdef STAR_SCHED_OVR_CNT_EN
  ,
  output logic [7:0]      o_ovr_cnt
`endif
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(STARS_COUNT - 1);

  sched_state_t    r_state;
  sched_state_t    w_state_nxt;
  logic [IDXW-1:0] r_star_idx;
  logic [IDXW-1:0] w_star_idx_nxt;
  logic            r_rd_buf;
  logic            w_rd_buf_nxt;
  logic            w_last;
  logic            w_busy;

  assign w_last = (r_star_idx == LastIdx);

  always_comb begin
    w_state_nxt    = r_state;
    w_star_idx_nxt = r_star_idx;
    w_rd_buf_nxt   = r_rd_buf;
    unique case (r_state)
      StInit: begin
        if (w_last) begin
          // First pass follows immediately so the back buffer is filled
          // before the first swap.
          w_state_nxt    = StUpdate;
          w_star_idx_nxt = '0;
        end else begin
          w_star_idx_nxt = r_star_idx + IDXW'(1);
        end
      end
      StUpdate: w_state_nxt = StReqX;
      StReqX: begin
        if (i_div_ack) w_state_nxt = StReqY;
      end
      StReqY: begin
        if (i_div_ack) w_state_nxt = StWrite;
      end
      StWrite: begin
        if (w_last) begin
          w_state_nxt    = StWaitFrame;
          w_star_idx_nxt = '0;
        end else begin
          w_state_nxt    = StUpdate;
          w_star_idx_nxt = r_star_idx + IDXW'(1);
        end
      end
      StWaitFrame: begin
        if (i_frame) begin
          w_state_nxt    = StUpdate;
          w_star_idx_nxt = '0;
          w_rd_buf_nxt   = ~r_rd_buf;
        end
      end
      default: begin
        w_state_nxt    = StInit;
        w_star_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StInit;
      r_star_idx <= '0;
      r_rd_buf   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_star_idx <= w_star_idx_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
    end
  end

  // Strobes are pure state decodes, so they are mutually exclusive by design.
  assign w_busy      = (r_state != StWaitFrame);
  assign o_init_en   = (r_state == StInit);
  assign o_upd_en    = (r_state == StUpdate);
  assign o_div_req   = (r_state == StReqX) || (r_state == StReqY);
  assign o_div_sel_y = (r_state == StReqY) ? DIV_SEL_Y : DIV_SEL_X;
  assign o_buf_we    = (r_state == StWrite);
  assign o_star_idx  = r_star_idx;
  assign o_rd_buf    = r_rd_buf;
  assign o_busy      = w_busy;
  // Reset dominates a coincident frame, so no overrun is flagged then.
  assign o_overrun   = i_frame & w_busy & ~i_rst;

`ifdef STAR_SCHED_OVR_CNT_EN
  sat_counter #(
    .W (8)
  ) u_ovr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (o_overrun),
    .o_cnt (o_ovr_cnt)
  );
`endif

endmodule

// File: tb/tb_star_frame_scheduler.sv
module tb_star_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame = 1'b0;
  logic       stray = 1'b0;
  logic       init_en, upd_en, div_req, div_sel_y, div_ack, buf_we, rd_buf, busy, overrun;
  logic [1:0] star_idx;
`ifdef STAR_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int unsigned age = 0;
  int total = 0;
  int bad = 0;
  int n_init = 0;
  int n_upd = 0;
  int n_we = 0;
  int n_hs = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Divider model: ack exactly 3 cycles after each request rise; stray adds extra acks.
  assign div_ack = stray | (div_req & (age == 3));
  always @(posedge clk) begin
    if (rst || !div_req || div_ack) age <= 0;
    else age <= age + 1;
  end

  star_frame_scheduler #(
    .STARS_COUNT (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_frame     (frame),
    .o_init_en   (init_en),
    .o_upd_en    (upd_en),
    .o_div_req   (div_req),
    .o_div_sel_y (div_sel_y),
    .i_div_ack   (div_ack),
    .o_buf_we    (buf_we),
    .o_star_idx  (star_idx),
    .o_rd_buf    (rd_buf),
    .o_busy      (busy),
    .o_overrun   (overrun)
`ifdef STAR_SCHED_OVR_CNT_EN
    ,
    .o_ovr_cnt   (ovr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: tally strobes mid-cycle, then land 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    n_init += int'(init_en);
    n_upd  += int'(upd_en);
    n_we   += int'(buf_we);
    n_hs   += int'(div_req & div_ack);
    chk("strobe_excl", 32'($countones({init_en, upd_en, buf_we, div_req}) <= 1), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_init = 0; n_upd = 0; n_we = 0; n_hs = 0;
  endtask

  task automatic run_pass(input int start, input int exp_len, input string tag);
    cyc = start;
    while (busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(tag, cyc, exp_len);
  endtask

  initial begin
    // 1: reset, seeding, first pass without a frame pulse
    tick();
    rst = 1'b0;
    #1;
    clr();
    chk("rst_rd_buf", rd_buf, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_div_req", div_req, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("init_en", init_en, 1'b1);
      chk("init_idx", star_idx, i);
      tick();
    end
    chk("init_cnt", n_init, 4);
    chk("pass1_upd", upd_en, 1'b1);
    chk("pass1_idx", star_idx, 0);
    clr();
    run_pass(0, 40, "pass1_len");
    chk("pass1_we", n_we, 4);
    chk("pass1_hs", n_hs, 8);
    chk("pass1_busy", busy, 1'b0);
    chk("pass1_rd_buf", rd_buf, 1'b0);

    // 2+3: frame swaps buffers; second frame during REQ_Y of star 2 is an overrun
    clr();
    frame = 1'b1;
    #1;
    chk("wait_no_ovr", overrun, 1'b0);
    tick();
    frame = 1'b0;
    #1;
    chk("swap_rd_buf", rd_buf, 1'b1);
    chk("swap_upd", upd_en, 1'b1);
    chk("swap_idx", star_idx, 0);
    for (int i = 0; i < 26; i++) tick();
    chk("reqy2_req", div_req, 1'b1);
    chk("reqy2_sel", div_sel_y, 1'b1);
    chk("reqy2_idx", star_idx, 2);
    frame = 1'b1;
    #1;
    chk("ovr_pulse", overrun, 1'b1);
    tick();
    frame = 1'b0;
    #1;
    chk("ovr_drop", overrun, 1'b0);
    chk("ovr_rd_buf", rd_buf, 1'b1);
    chk("ovr_idx", star_idx, 2);
    chk("ovr_still_y", div_sel_y, 1'b1);
    run_pass(27, 40, "pass2_len");
    chk("pass2_we", n_we, 4);
    chk("pass2_hs", n_hs, 8);
    chk("pass2_rd_buf", rd_buf, 1'b1);

    // 5: stray acks in UPDATE and WAIT_FRAME ignored; ack on request rise accepted
    clr();
    frame = 1'b1;
    #1;
    tick();
    frame = 1'b0;
    stray = 1'b1;
    #1;
    chk("p3_rd_buf", rd_buf, 1'b0);
    chk("p3_upd", upd_en, 1'b1);
    tick();
    stray = 1'b0;
    #1;
    chk("stray_upd_reqx", div_req, 1'b1);
    chk("stray_upd_sel", div_sel_y, 1'b0);
    stray = 1'b1;
    #1;
    tick();
    stray = 1'b0;
    #1;
    chk("fast_ack_sel", div_sel_y, 1'b1);
    chk("fast_ack_req", div_req, 1'b1);
    run_pass(2, 37, "pass3_len");
    chk("pass3_we", n_we, 4);
    chk("pass3_hs", n_hs, 8);
    stray = 1'b1;
    #1;
    tick();
    stray = 1'b0;
    #1;
    chk("stray_wait_busy", busy, 1'b0);
    chk("stray_wait_we", n_we, 4);
    chk("stray_wait_rd", rd_buf, 1'b0);

    // 4: reset during REQ_X of star 1 drops the request and reseeds
    clr();
    frame = 1'b1;
    #1;
    tick();
    frame = 1'b0;
    #1;
    chk("p4_rd_buf", rd_buf, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    chk("reqx1_req", div_req, 1'b1);
    chk("reqx1_sel", div_sel_y, 1'b0);
    chk("reqx1_idx", star_idx, 1);
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_req", div_req, 1'b0);
    chk("mid_rst_init", init_en, 1'b1);
    chk("mid_rst_idx", star_idx, 0);
    chk("mid_rst_rd_buf", rd_buf, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    clr();
    run_pass(0, 40, "pass4_len");
    chk("pass4_we", n_we, 4);

    // Reset coincident with frame in WAIT_FRAME: reset wins
    frame = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_frame_ovr", overrun, 1'b0);
    tick();
    frame = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_frame_rd", rd_buf, 1'b0);
    chk("rst_frame_init", init_en, 1'b1);
    chk("rst_frame_busy", busy, 1'b1);

`ifdef STAR_SCHED_OVR_CNT_EN
    // 6: overrun counter saturates, cleared by reset
    frame = 1'b1;
    #1;
    for (int i = 0; i < 400; i++) tick();
    frame = 1'b0;
    #1;
    chk("ovr_cnt_sat", ovr_cnt, 8'hFF);
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("ovr_cnt_clr", ovr_cnt, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
